// File: rtl/snake_ctrl_if.sv
// snake_ctrl_if: link to snake_pos -- master drives step/dir/grow, slave returns head+4 segment positions and the food cell
interface snake_ctrl_if;
    logic       step;
    logic       grow;
    logic [1:0] dir;
    logic [8:0] snake_x0, snake_x1, snake_x2, snake_x3, snake_x4;
    logic [8:0] snake_y0, snake_y1, snake_y2, snake_y3, snake_y4;
    logic [8:0] food_x, food_y;
    modport master (
        output step, dir, grow,
        input  snake_x0, snake_x1, snake_x2, snake_x3, snake_x4,
        input  snake_y0, snake_y1, snake_y2, snake_y3, snake_y4,
        input  food_x, food_y
    );
    modport slave (
        input  step, dir, grow,
        output snake_x0, snake_x1, snake_x2, snake_x3, snake_x4,
        output snake_y0, snake_y1, snake_y2, snake_y3, snake_y4,
        output food_x, food_y
    );
endinterface

// File: rtl/snake_ctrl.sv
// snake_ctrl: snake game FSM -- in: tick, btn_*, bus (segments/food); out: bus.step/dir/grow, state, score, game_over, interval; define SNAKE_DIR_QUEUE_EN for a 2-entry direction FIFO
module snake_ctrl #(
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int SCORE_W    = 8,
    parameter int SPEED_STEP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_start,
    snake_ctrl_if.master       bus,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic [1:0]         interval
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} st_t;
    localparam logic signed [9:0] GW = 10'(GRID_W);
    localparam logic signed [9:0] GH = 10'(GRID_H);
    st_t st;
    logic hold, press, clr, go, wall, self_hit, food, collide, adv;
    logic [1:0] pd, d;
    logic signed [9:0] nx, ny;
    logic [19:0] nh;
    logic [SCORE_W-1:0] lvl;
    assign state = st;
    assign press = (st == RUN || st == PAUSE) && (btn_up || btn_down || btn_left || btn_right);
    assign pd = btn_up ? 2'd3 : btn_down ? 2'd1 : btn_left ? 2'd2 : 2'd0;
    assign clr = st == OVER && btn_start;
    // a tick landing while step is high is held: snake_pos has not moved the head yet
    assign go = st == RUN && !btn_start && (tick || hold) && !bus.step;
    assign nx = $signed({1'b0, bus.snake_x0}) + (d == 2'd0 ? 10'sd1 : d == 2'd2 ? -10'sd1 : 10'sd0);
    assign ny = $signed({1'b0, bus.snake_y0}) + (d == 2'd1 ? 10'sd1 : d == 2'd3 ? -10'sd1 : 10'sd0);
    assign nh = {nx, ny};
    assign wall = nx[9] || ny[9] || nx >= GW || ny >= GH;
    assign food = nh == {1'b0, bus.food_x, 1'b0, bus.food_y};
    // the tail cell only vacates when the snake does not grow
    assign self_hit = nh == {1'b0, bus.snake_x1, 1'b0, bus.snake_y1}
                   || nh == {1'b0, bus.snake_x2, 1'b0, bus.snake_y2}
                   || nh == {1'b0, bus.snake_x3, 1'b0, bus.snake_y3}
                   || (food && nh == {1'b0, bus.snake_x4, 1'b0, bus.snake_y4});
    assign collide = wall || self_hit;
    assign adv = go && !collide;
    assign lvl = score / SCORE_W'(SPEED_STEP);
`ifdef SNAKE_DIR_QUEUE_EN
    logic [1:0] q0, q1, qn0, qn1, rf, qc, qcn;
    assign d = qc != 2'd0 ? q0 : bus.dir;
    assign rf = qc == 2'd0 ? bus.dir : qc == 2'd1 ? q0 : q1;
    always_comb begin
        qn0 = q0;
        qn1 = q1;
        qcn = qc;
        if (adv && qc != 2'd0) begin
            qn0 = q1;
            qcn = qc - 2'd1;
        end
        if (press && pd != rf && pd != (rf ^ 2'b10) && qcn != 2'd2) begin
            if (qcn == 2'd0) qn0 = pd;
            else qn1 = pd;
            qcn = qcn + 2'd1;
        end
        if (clr) qcn = 2'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0 <= 2'd0;
            q1 <= 2'd0;
            qc <= 2'd0;
        end else begin
            q0 <= qn0;
            q1 <= qn1;
            qc <= qcn;
        end
    end
`else
    logic pv;
    logic [1:0] pdir;
    // any press is stored; a reversal is rejected when the tick consumes it
    assign d = (pv && pdir != (bus.dir ^ 2'b10)) ? pdir : bus.dir;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= 1'b0;
            pdir <= 2'd0;
        end else begin
            pv <= press || (pv && !adv && !clr);
            if (press) pdir <= pd;
        end
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            bus.dir <= 2'd0;
            bus.step <= 1'b0;
            bus.grow <= 1'b0;
            score <= '0;
            game_over <= 1'b0;
            interval <= 2'd0;
            hold <= 1'b0;
        end else begin
            bus.step <= adv;
            bus.grow <= adv && food;
            hold <= st == RUN && !btn_start && (tick || hold) && bus.step;
            interval <= lvl > SCORE_W'(3) ? 2'd3 : lvl[1:0];
            if (adv) bus.dir <= d;
            if (adv && food && score != '1) score <= score + SCORE_W'(1);
            case (st)
                IDLE:  if (btn_start) st <= RUN;
                RUN: begin
                    if (btn_start) st <= PAUSE;
                    else if (go && collide) begin
                        st <= OVER;
                        game_over <= 1'b1;
                    end
                end
                PAUSE: if (btn_start) st <= RUN;
                OVER: begin
                    if (btn_start) begin
                        st <= IDLE;
                        game_over <= 1'b0;
                        score <= '0;
                        bus.dir <= 2'd0;
                    end
                end
            endcase
        end
    end
endmodule
